// File: rtl/sample_buffer_ring_if.sv
// Bus bundle for sample_buffer_ring: host/stream control in, registered read data and FIFO status out.
interface sample_buffer_ring_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  mode;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write;
  logic                  rd_en;
  logic                  output_enable;
  logic                  clear_flags;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output mode, address, data_in, write, rd_en, output_enable, clear_flags,
    input  data_out, out_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  mode, address, data_in, write, rd_en, output_enable, clear_flags,
    output data_out, out_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/sample_buffer_ring.sv
// Shared sample store usable as an addressed RAM (mode=0) or a ring FIFO (mode=1).
module sample_buffer_ring #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sample_buffer_ring_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_mode_q;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_out_valid, r_overflow, r_underflow;

  logic                  w_switch, w_full, w_empty, w_fifo;
  logic                  w_pop, w_push, w_ovf_evt, w_unf_evt, w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr, w_mem_raddr;

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  // A mode change swallows that cycle's strobes entirely.
  assign w_switch = (bus.mode != r_mode_q);
  assign w_fifo   = bus.mode && !w_switch;

  assign w_pop     = w_fifo && bus.rd_en && bus.output_enable && !w_empty;
  assign w_push    = w_fifo && bus.write && (!w_full || w_pop);
  assign w_ovf_evt = w_fifo && bus.write && w_full && !w_pop;
  // No show-ahead: a push landing this cycle cannot satisfy a pop on empty.
  assign w_unf_evt = w_fifo && bus.rd_en && bus.output_enable && w_empty;

  assign w_mem_we    = rst_n && (w_push || (!bus.mode && !w_switch && bus.write));
  assign w_mem_waddr = bus.mode ? r_wr_ptr : bus.address;
  assign w_mem_raddr = bus.mode ? r_rd_ptr : bus.address;

  // Storage is deliberately not reset so RAM contents survive rst_n and mode flips.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode_q    <= bus.mode;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_mode_q <= bus.mode;
      if (w_switch) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_data_out  <= '0;
        r_out_valid <= 1'b0;
      end else if (!bus.mode) begin
        // Read-first: the nonblocking read sees the word before this cycle's write.
        r_out_valid <= bus.output_enable;
        r_data_out  <= bus.output_enable ? r_mem[w_mem_raddr] : '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        r_out_valid <= w_pop;
        if (w_pop)                      r_data_out <= r_mem[w_mem_raddr];
        else if (!bus.output_enable)    r_data_out <= '0;
      end
      r_overflow  <= w_ovf_evt || (r_overflow  && !bus.clear_flags);
      r_underflow <= w_unf_evt || (r_underflow && !bus.clear_flags);
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_sample_buffer_ring.sv
// Bench for sample_buffer_ring: RAM vector table, FIFO corner sequences, and randomized traffic vs a queue model.
module tb_sample_buffer_ring;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sample_buffer_ring_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sample_buffer_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a data queue for FIFO order plus a flat array for RAM contents.
  int          m_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  int          m_wpos;
  logic        m_mode_q;
  logic [DW-1:0] m_dout;
  logic        m_valid, m_ovf, m_unf;

  typedef struct {
    string       name;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic        wr;
    logic        oe;
    logic [DW-1:0] exp_dout;
    logic        exp_vld;
  } vec_t;

  task automatic set_in(input logic r, input logic md, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic w, input logic rd, input logic oe, input logic clr);
    rst_n = r; bus.mode = md; bus.address = a; bus.data_in = d;
    bus.write = w; bus.rd_en = rd; bus.output_enable = oe; bus.clear_flags = clr;
  endtask

  task automatic model_step();
    logic pop, push;
    logic [DW-1:0] nd;
    if (!rst_n) begin
      m_mode_q = bus.mode; m_q.delete(); m_wpos = 0;
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (bus.mode != m_mode_q) begin
      m_mode_q = bus.mode; m_q.delete(); m_wpos = 0;
      m_dout = '0; m_valid = 1'b0;
      if (bus.clear_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
      return;
    end
    if (!bus.mode) begin
      nd = bus.output_enable ? m_mem[bus.address] : '0;
      if (bus.write) m_mem[bus.address] = bus.data_in;
      m_dout = nd; m_valid = bus.output_enable;
      if (bus.clear_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      pop  = bus.rd_en && bus.output_enable && (m_q.size() > 0);
      push = bus.write && ((m_q.size() < DEPTH) || pop);
      if (bus.clear_flags) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (bus.write && !push) m_ovf = 1'b1;
      if (bus.rd_en && bus.output_enable && m_q.size() == 0) m_unf = 1'b1;
      m_valid = pop;
      if (pop) m_dout = DW'(m_q.pop_front());
      else if (!bus.output_enable) m_dout = '0;
      if (push) begin
        m_q.push_back(int'(bus.data_in));
        m_mem[m_wpos] = bus.data_in;
        m_wpos = (m_wpos + 1) % DEPTH;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input string nm);
    int mc;
    model_step();
    @(posedge clk); #1;
    mc = m_q.size();
    n_chk++;
    if (bus.data_out !== m_dout || bus.out_valid !== m_valid || int'(bus.count) != mc ||
        bus.full !== (mc == DEPTH) || bus.empty !== (mc == 0) ||
        bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
      n_err++;
      $display("FAIL %s: got dout=%0d vld=%0b cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b expected dout=%0d vld=%0b cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
               nm, bus.data_out, bus.out_valid, bus.count, bus.full, bus.empty, bus.overflow, bus.underflow,
               m_dout, m_valid, mc, mc == DEPTH, mc == 0, m_ovf, m_unf);
    end
  endtask

  initial begin
    vec_t vt[$];
    vt.push_back('{"ram_wr0",   4'd0, 16'd123, 1'b1, 1'b0, 16'd0,   1'b0});
    vt.push_back('{"ram_wr1",   4'd1, 16'd234, 1'b1, 1'b0, 16'd0,   1'b0});
    vt.push_back('{"ram_wr2",   4'd2, 16'd345, 1'b1, 1'b0, 16'd0,   1'b0});
    vt.push_back('{"ram_rd0",   4'd0, 16'd0,   1'b0, 1'b1, 16'd123, 1'b1});
    vt.push_back('{"ram_rd1",   4'd1, 16'd0,   1'b0, 1'b1, 16'd234, 1'b1});
    vt.push_back('{"ram_rd2",   4'd2, 16'd0,   1'b0, 1'b1, 16'd345, 1'b1});
    vt.push_back('{"ram_oe0",   4'd2, 16'd0,   1'b0, 1'b0, 16'd0,   1'b0});
    vt.push_back('{"ram_wr3",   4'd3, 16'd10,  1'b1, 1'b0, 16'd0,   1'b0});
    vt.push_back('{"ram_rdw3",  4'd3, 16'd20,  1'b1, 1'b1, 16'd10,  1'b1});
    vt.push_back('{"ram_rd3",   4'd3, 16'd0,   1'b0, 1'b1, 16'd20,  1'b1});

    set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("reset");
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_count", int'(bus.count), 0);

    // Give every word a known value before any read.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, AW'(i), DW'(1000 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick("ram_init");
    end

    foreach (vt[i]) begin
      set_in(1'b1, 1'b0, vt[i].addr, vt[i].din, vt[i].wr, 1'b0, vt[i].oe, 1'b0);
      tick(vt[i].name);
      chk({vt[i].name, "_dout"}, int'(bus.data_out), int'(vt[i].exp_dout));
      chk({vt[i].name, "_vld"},  int'(bus.out_valid), int'(vt[i].exp_vld));
    end

    // Switch to FIFO; the push strobe on the switch edge must be dropped.
    set_in(1'b1, 1'b1, '0, 16'd555, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("to_fifo");
    chk("to_fifo_count", int'(bus.count), 0);

    for (int i = 1; i <= DEPTH; i++) begin
      set_in(1'b1, 1'b1, '0, DW'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      tick("fill");
    end
    chk("fill_full", int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 16);
    set_in(1'b1, 1'b1, '0, 16'd99, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("push_full");
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.count), 16);

    for (int i = 1; i <= DEPTH; i++) begin
      set_in(1'b1, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick("drain");
      chk("drain_order", int'(bus.data_out), i);
    end
    chk("drain_empty", int'(bus.empty), 1);

    set_in(1'b1, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick("pop_empty");
    chk("unf_set", int'(bus.underflow), 1);
    chk("unf_vld", int'(bus.out_valid), 0);
    chk("clr_ovf", int'(bus.overflow), 0);

    // Push+pop on empty: push lands, pop is an underflow.
    set_in(1'b1, 1'b1, '0, 16'd700, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("pushpop_empty");
    chk("pushpop_empty_cnt", int'(bus.count), 1);

    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, '0, DW'(200 + i), 1'b1, 1'b1, 1'b1, 1'b0);
      tick("wrap_stream");
    end

    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b1, '0, DW'(300 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      tick("refill");
    end
    set_in(1'b1, 1'b1, '0, 16'd77, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("pushpop_full");
    chk("pushpop_full_cnt", int'(bus.count), 16);

    set_in(1'b1, 1'b1, '0, 16'd88, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("clr_vs_ovf");
    chk("clr_vs_ovf_flag", int'(bus.overflow), 1);

    // Drain to 5 words, then flip mode with a write pending.
    for (int i = 0; i < DEPTH - 5; i++) begin
      set_in(1'b1, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick("to_five");
    end
    chk("five_count", int'(bus.count), 5);
    set_in(1'b1, 1'b0, 4'd0, 16'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("switch_ram");
    chk("switch_empty", int'(bus.empty), 1);

    set_in(1'b1, 1'b1, '0, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("back_fifo");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, '0, DW'(400 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      tick("prerst_push");
    end
    set_in(1'b0, 1'b1, '0, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("mid_reset");
    chk("mid_reset_cnt", int'(bus.count), 0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("post_rst_switch");
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick("ram_after_rst");
    end

    for (int i = 0; i < 600; i++) begin
      logic md, clr;
      md  = ($urandom_range(0, 39) == 0) ? ~m_mode_q : m_mode_q;
      clr = (md == 1'b1 && md == m_mode_q) ? ($urandom_range(0, 9) == 0) : 1'b0;
      set_in($urandom_range(0, 149) != 0, md, AW'($urandom), DW'($urandom),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4) != 0, clr);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sample_buffer_ring.md
Name: sample_buffer_ring

Overview:
Parametrised successor to the 16x16 addressed sample buffer in the audio datapath. One storage array runs in one of two modes: addressed RAM mode (host random access) or ring/FIFO mode (streaming push/pop with occupancy and error flags). Registered output with output-enable gating. It sits between the sample source (ADC/host writer) and the processing core.

Parameters:
DATA_WIDTH, 16, sample word width in bits.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
clk  input  1  single system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
mode  input  1  0 = RAM mode, 1 = FIFO mode.
address  input  ADDR_WIDTH  RAM-mode read/write address; ignored in FIFO mode.
data_in  input  DATA_WIDTH  write/push data.
write  input  1  RAM: write strobe; FIFO: push strobe.
rd_en  input  1  FIFO pop strobe; ignored in RAM mode.
output_enable  input  1  0 forces data_out/out_valid to 0 and blocks pops.
data_out  output  DATA_WIDTH  registered read data.
out_valid  output  1  data_out carries a fresh read this cycle.
count  output  ADDR_WIDTH+1  FIFO occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
overflow  output  1  sticky: push refused while full.
underflow  output  1  sticky: pop attempted while empty.
clear_flags  input  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n=0 at edge): wr_ptr=rd_ptr=0, count=0, data_out=0, out_valid=0, empty=1, full=0, overflow=0, underflow=0, mode_q=mode. Memory contents not reset. Reset beats every other input.
- mode_q registers mode. On an edge where mode != mode_q: wr_ptr, rd_ptr, count cleared; write/rd_en that cycle ignored; data_out=0, out_valid=0. Memory preserved.
- RAM mode: write=1 -> mem[address] <= data_in. If output_enable=1, data_out <= mem[address] with 1-cycle latency, out_valid=1; read-during-write same address returns OLD data (read-first). If output_enable=0, data_out=0, out_valid=0. Pointers/count/flags untouched.
- FIFO mode push: write=1 and (!full or pop accepted same cycle) -> mem[wr_ptr] <= data_in, wr_ptr+1 mod DEPTH. write=1 while full with no accepted pop -> data dropped, overflow set.
- FIFO mode pop: accepted when rd_en=1, output_enable=1, !empty -> data_out <= mem[rd_ptr] next edge, out_valid=1 for one cycle, rd_ptr+1 mod DEPTH. rd_en=1 with oe=1 and empty -> underflow set, out_valid=0, data_out holds. rd_en with oe=0 -> no pop, no flag, data_out=0.
- No show-ahead: push+pop on empty -> push accepted, pop is underflow, count 0->1.
- count: +1 push only, -1 pop only, unchanged for both or neither; full/empty combinational from count.
- Pointer wrap: DEPTH-1 -> 0, no flag.
- out_valid=0 on any cycle without an accepted read.
- clear_flags=1 clears both sticky flags; a new overflow/underflow event in the same cycle wins (flag stays 1).

Test Plan:
- RAM: write 123@0, 234@1, 345@2, oe=1, read addr 0,1,2 -> data_out 123,234,345 one cycle after each address, out_valid=1; oe=0 -> data_out=0, out_valid=0.
- RAM read-during-write: mem[3]=10, write 20@3 while reading 3 -> data_out=10; next read -> 20.
- FIFO fill/wrap: push 16 words 1..16 -> full=1, count=16; push 99 -> overflow=1, count stays 16; pop 16 -> data_out 1..16 in order, empty=1; push/pop 20 more -> correct order across wrap.
- FIFO edges: pop on empty -> underflow=1, out_valid=0; push+pop when full -> count stays 16, pushed word appears in order; clear_flags with simultaneous overflow event -> overflow stays 1.
- Mode switch/reset: 5 words in FIFO, toggle mode -> count=0, empty=1, write that cycle ignored; rst_n=0 mid-stream for one edge -> all outputs at reset values, old RAM contents still readable in RAM mode.
